// File: rtl/scc_sound.sv
// Konami SCC (K051649) sound device: CPU-visible wave RAM and channel registers,
// five wavetable channels, and a registered signed mix of the channel outputs.
module scc_sound #(
  parameter int OUT_W = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    cs,
  input  logic                    wr,
  input  logic                    rd,
  input  logic [7:0]              addr,
  input  logic [7:0]              din,
  output logic [7:0]              dout,
  output logic signed [OUT_W-1:0] sound
);

  localparam int NCH = 5;

  logic [7:0]              wave_q [128];
  logic [11:0]             freq_q [NCH];
  logic [11:0]             freq_d [NCH];
  logic [11:0]             cnt_q  [NCH];
  logic [11:0]             cnt_d  [NCH];
  logic [4:0]              ptr_q  [NCH];
  logic [4:0]              ptr_d  [NCH];
  logic [3:0]              vol_q  [NCH];
  logic [3:0]              vol_d  [NCH];
  logic [7:0]              wsel   [NCH];
  logic [NCH-1:0]          en_q, en_d;
  logic [NCH-1:0]          freq_clr;
  logic [7:0]              dout_q, dout_d;
  logic signed [OUT_W-1:0] sound_q, sound_d, mix_sum;
  logic                    wr_en, rd_en, reg_wr;

  // A write in the same cycle as a read wins; the read is dropped.
  assign wr_en  = cs & wr;
  assign rd_en  = cs & rd & ~wr;
  assign reg_wr = wr_en & (addr[7:5] == 3'b100);

  // Wave RAM write port; contents survive reset, but no write lands while reset is high.
  always_ff @(posedge clk) begin
    if (wr_en && !addr[7] && !reset) wave_q[addr[6:0]] <= din;
  end

  // Playback fetch: channel 4 shares channel 3's 32-byte bank.
  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      wsel[n] = wave_q[{2'(n < 4 ? n : 3), ptr_q[n]}];
    end
  end

  // Mix: signed sample times unsigned volume per enabled channel, summed without saturation.
  always_comb begin
    mix_sum = '0;
    for (int n = 0; n < NCH; n++) begin
      if (en_q[n]) begin
        mix_sum = mix_sum + ($signed({{(OUT_W-8){wsel[n][7]}}, wsel[n]}) *
                             $signed({{(OUT_W-4){1'b0}}, vol_q[n]}));
      end
    end
  end

  // Register decode, read data, channel stepping and output sample next-state.
  always_comb begin
    freq_d   = freq_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    vol_d    = vol_q;
    en_d     = en_q;
    dout_d   = dout_q;
    sound_d  = sound_q;
    freq_clr = '0;

    if (rd_en) dout_d = addr[7] ? 8'hFF : wave_q[addr[6:0]];

    if (reg_wr) begin
      for (int n = 0; n < NCH; n++) begin
        if (addr[3:1] == 3'(n)) begin
          if (addr[0]) freq_d[n][11:8] = din[3:0];
          else         freq_d[n][7:0]  = din;
          freq_clr[n] = 1'b1;
        end
        if (addr[3:0] == 4'(n + 10)) vol_d[n] = din[3:0];
      end
      if (addr[3:0] == 4'hF) en_d = din[4:0];
    end

    if (ce) begin
      sound_d = mix_sum;
      for (int n = 0; n < NCH; n++) begin
        if (freq_q[n] > 12'd8) begin
          if (cnt_q[n] == 12'd0) begin
            cnt_d[n] = freq_q[n];
            ptr_d[n] = ptr_q[n] + 5'd1;
          end else begin
            cnt_d[n] = cnt_q[n] - 12'd1;
          end
        end
      end
    end

    // A frequency write restarts the step timer but never moves the pointer.
    for (int n = 0; n < NCH; n++) begin
      if (freq_clr[n]) begin
        cnt_d[n] = '0;
        ptr_d[n] = ptr_q[n];
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NCH; n++) begin
        freq_q[n] <= '0;
        cnt_q[n]  <= '0;
        ptr_q[n]  <= '0;
        vol_q[n]  <= '0;
      end
      en_q    <= '0;
      dout_q  <= 8'hFF;
      sound_q <= '0;
    end else begin
      freq_q  <= freq_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      vol_q   <= vol_d;
      en_q    <= en_d;
      dout_q  <= dout_d;
      sound_q <= sound_d;
    end
  end

  assign dout  = dout_q;
  assign sound = sound_q;

endmodule
